mem_stage: RTL and testbench



---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_stage_load_ext.sv | 26 ++
 rtl/mem_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared encodings for the MEM stage.
//   - memory access kinds presented by EX/MEM
//   - funct3 width codes for loads and stores
//   - byte-sequencer FSM states
//   - helper that maps a width code to its byte count
package mem_stage_pkg;

    localparam logic [1:0] MEM_KIND_NONE  = 2'b00;
    localparam logic [1:0] MEM_KIND_LOAD  = 2'b01;
    localparam logic [1:0] MEM_KIND_STORE = 2'b10;

    localparam logic [2:0] MEM_W_LB  = 3'b000;
    localparam logic [2:0] MEM_W_LH  = 3'b001;
    localparam logic [2:0] MEM_W_LW  = 3'b010;
    localparam logic [2:0] MEM_W_LBU = 3'b100;
    localparam logic [2:0] MEM_W_LHU = 3'b101;
    localparam logic [2:0] MEM_W_SB  = 3'b000;
    localparam logic [2:0] MEM_W_SH  = 3'b001;
    localparam logic [2:0] MEM_W_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_XFER = 2'b01,
        ST_LAST = 2'b10
    } mem_state_t;

    // Number of bytes moved for a width code (B/BU -> 1, H/HU -> 2, W -> 4).
    function automatic logic [2:0] mem_byte_count(input logic [2:0] width);
        logic [2:0] n;
        case (width)
            3'b000, 3'b100: n = 3'd1;
            3'b001, 3'b101: n = 3'd2;
            default:        n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// mem_load_ext: combinational load-result formatter.
// Ports:
//   bytes_in  in  32    assembled little-endian bytes (byte 0 in [7:0])
//   width     in  3     funct3 width code
//   result    out XLEN  sign- or zero-extended load value
module mem_load_ext #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     bytes_in,
    input  logic [2:0]      width,
    output logic [XLEN-1:0] result
);
    import mem_stage_pkg::*;

    always_comb begin
        result = XLEN'(bytes_in);
        case (width)
            MEM_W_LB:  result = {{(XLEN-8){bytes_in[7]}}, bytes_in[7:0]};
            MEM_W_LH:  result = {{(XLEN-16){bytes_in[15]}}, bytes_in[15:0]};
            MEM_W_LBU: result = {{(XLEN-8){1'b0}}, bytes_in[7:0]};
            MEM_W_LHU: result = {{(XLEN-16){1'b0}}, bytes_in[15:0]};
            default:   result = XLEN'(bytes_in);
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the RV32I pipeline. ALU results pass straight
// through; loads/stores are sequenced one byte at a time over the shared
// 8-bit memory port while stall_req freezes the upstream stages.
// Ports:
//   clk, rst (sync, active-high), rdy (global enable)
//   ex_*      in   EX/MEM latch contents (data, rd, enable, kind, width, addr)
//   wb_*      out  result towards MEM/WB
//   stall_req out  freeze request upstream
//   mem_*     byte port to the memory arbiter (req/we/a/dout out, din/grant in)
// Build option: define MEM_FWD_EN to add fwd_rd_enable/fwd_rd_addr/
// fwd_rd_data, a copy of wb_* for ID-stage forwarding.
module mem_stage #(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [XLEN-1:0]   ex_rd_data,
    input  logic [4:0]        ex_rd_addr,
    input  logic              ex_rd_enable,
    input  logic [1:0]        ex_mem_kind,
    input  logic [2:0]        ex_mem_width,
    input  logic [ADDR_W-1:0] ex_mem_addr,
    output logic [XLEN-1:0]   wb_rd_data,
    output logic [4:0]        wb_rd_addr,
    output logic              wb_rd_enable,
    output logic              stall_req,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_a,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    input  logic              mem_grant
`ifdef MEM_FWD_EN
    ,
    output logic              fwd_rd_enable,
    output logic [4:0]        fwd_rd_addr,
    output logic [XLEN-1:0]   fwd_rd_data
`endif
);
    import mem_stage_pkg::*;

    mem_state_t        state_reg;
    logic [2:0]        k_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [2:0]        width_reg;
    logic              store_reg;
    logic [XLEN-1:0]   data_reg;
    logic [4:0]        rd_addr_reg;
    logic              rd_en_reg;
    logic              rd_pending_reg;
    logic [7:0]        asm_reg [4];

    logic [2:0]        n_bytes;
    logic [2:0]        last_idx;
    logic              mem_op;
    logic              in_xfer;
    logic              last_grant;
    logic [1:0]        pend_idx;
    logic [31:0]       ld_word;
    logic [XLEN-1:0]   ld_result;

    assign n_bytes  = mem_byte_count(width_reg);
    assign last_idx = n_bytes - 3'd1;
    assign mem_op   = (ex_mem_kind == MEM_KIND_LOAD) || (ex_mem_kind == MEM_KIND_STORE);
    assign in_xfer  = (state_reg == ST_XFER);

    // Gating with rst keeps the port quiet in the reset cycle of an abandoned access.
    assign mem_req    = in_xfer && rdy && !rst;
    assign mem_we     = in_xfer && store_reg;
    assign mem_a      = in_xfer ? base_reg + ADDR_W'(k_reg) : '0;
    assign mem_dout   = (in_xfer && store_reg) ? data_reg[{k_reg[1:0], 3'b000} +: 8] : 8'h00;
    assign last_grant = mem_req && mem_grant && (k_reg == last_idx);

    // k has already moved past the byte whose read data arrives this cycle.
    assign pend_idx = k_reg[1:0] - 2'd1;

    // In the completion cycle the final byte comes straight from mem_din.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign ld_word[8*gi +: 8] =
                ((state_reg == ST_LAST) && (last_idx[1:0] == 2'(gi))) ? mem_din : asm_reg[gi];
        end
    endgenerate

    mem_load_ext #(.XLEN(XLEN)) u_load_ext (
        .bytes_in (ld_word),
        .width    (width_reg),
        .result   (ld_result)
    );

    always_comb begin
        wb_rd_data   = '0;
        wb_rd_addr   = '0;
        wb_rd_enable = 1'b0;
        stall_req    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (mem_op) begin
                    stall_req = 1'b1;
                end else begin
                    wb_rd_data   = ex_rd_data;
                    wb_rd_addr   = ex_rd_addr;
                    wb_rd_enable = ex_rd_enable;
                end
            end
            ST_XFER: begin
                // A store completes in the cycle its last byte is granted.
                if (store_reg && last_grant) begin
                    wb_rd_addr = rd_addr_reg;
                end else begin
                    stall_req = 1'b1;
                end
            end
            ST_LAST: begin
                wb_rd_data   = ld_result;
                wb_rd_addr   = rd_addr_reg;
                wb_rd_enable = rd_en_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            k_reg          <= 3'd0;
            base_reg       <= '0;
            width_reg      <= 3'd0;
            store_reg      <= 1'b0;
            data_reg       <= '0;
            rd_addr_reg    <= 5'd0;
            rd_en_reg      <= 1'b0;
            rd_pending_reg <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                asm_reg[i] <= 8'h00;
            end
        end else if (rdy) begin
            rd_pending_reg <= mem_req && mem_grant && !mem_we;
            if (rd_pending_reg && in_xfer) begin
                asm_reg[pend_idx] <= mem_din;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (mem_op) begin
                        base_reg    <= ex_mem_addr;
                        width_reg   <= ex_mem_width;
                        store_reg   <= (ex_mem_kind == MEM_KIND_STORE);
                        data_reg    <= ex_rd_data;
                        rd_addr_reg <= ex_rd_addr;
                        rd_en_reg   <= ex_rd_enable;
                        k_reg       <= 3'd0;
                        state_reg   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (mem_req && mem_grant) begin
                        k_reg <= k_reg + 3'd1;
                        if (k_reg == last_idx) begin
                            state_reg <= store_reg ? ST_IDLE : ST_LAST;
                        end
                    end
                end
                ST_LAST: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

`ifdef MEM_FWD_EN
    assign fwd_rd_enable = wb_rd_enable && !stall_req;
    assign fwd_rd_addr   = wb_rd_addr;
    assign fwd_rd_data   = wb_rd_data;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed plus randomized bench for mem_stage. Memory is a
// pure function of address; expected load values and byte sequences are
// derived from the access rules with plain arithmetic.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [31:0] ex_rd_data = '0;
    logic [4:0]  ex_rd_addr = '0;
    logic        ex_rd_enable = 1'b0;
    logic [1:0]  ex_mem_kind = '0;
    logic [2:0]  ex_mem_width = '0;
    logic [31:0] ex_mem_addr = '0;
    logic [31:0] wb_rd_data;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_enable;
    logic        stall_req;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        mem_grant = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.ADDR_W(32), .XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .ex_rd_data   (ex_rd_data),
        .ex_rd_addr   (ex_rd_addr),
        .ex_rd_enable (ex_rd_enable),
        .ex_mem_kind  (ex_mem_kind),
        .ex_mem_width (ex_mem_width),
        .ex_mem_addr  (ex_mem_addr),
        .wb_rd_data   (wb_rd_data),
        .wb_rd_addr   (wb_rd_addr),
        .wb_rd_enable (wb_rd_enable),
        .stall_req    (stall_req),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_a        (mem_a),
        .mem_dout     (mem_dout),
        .mem_din      (mem_din),
        .mem_grant    (mem_grant)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h78;
            32'h101: return 8'h56;
            32'h102: return 8'h34;
            32'h103: return 8'h12;
            32'h200: return 8'h80;
            32'h201: return 8'h80;
            32'h202: return 8'hFF;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
        endcase
    endfunction

    // Read data appears the cycle after a granted read and holds until the next read.
    always @(posedge clk) begin
        if (rst) mem_din <= 8'h00;
        else if (rdy && mem_req && mem_grant && !mem_we) mem_din <= mem_byte(mem_a);
    end

    function automatic int n_of(input logic [2:0] w);
        if (w == 3'b000 || w == 3'b100) return 1;
        if (w == 3'b001 || w == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] w, input logic [31:0] a);
        longint v;
        v = 0;
        for (int i = 0; i < n_of(w); i++) v = v + (longint'(mem_byte(a + i)) << (8 * i));
        if (w == 3'b000 && v >= 128)   v = v - 256;
        if (w == 3'b001 && v >= 32768) v = v - 65536;
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic alu_op(input logic [31:0] data, input logic [4:0] rd, input logic en);
        @(negedge clk);
        ex_mem_kind = 2'b00; ex_rd_data = data; ex_rd_addr = rd; ex_rd_enable = en;
        ex_mem_width = 3'($urandom); ex_mem_addr = $urandom; rdy = 1'b1; mem_grant = 1'b0;
        #1;
        chk("alu_data", wb_rd_data, data);
        chk("alu_rd", 32'(wb_rd_addr), 32'(rd));
        chk("alu_en", 32'(wb_rd_enable), 32'(en));
        chk("alu_stall", 32'(stall_req), 0);
        chk("alu_req", 32'(mem_req), 0);
        $display("ALU data=%h rd=%0d en=%0d", data, rd, en);
    endtask

    // One memory op; abort_cycle >= 0 raises rst in that cycle and returns.
    task automatic run_op(input logic [1:0] kind, input logic [2:0] w, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] rd, input logic rden,
                          input bit rnd, input logic [15:0] nogrant_mask,
                          input logic [15:0] rdylo_mask, input int abort_cycle,
                          input int exp_latency);
        int  n;
        int  g;
        bit  is_store;
        bit  done;
        n = n_of(w); g = 0; done = 0; is_store = (kind == 2'b10);
        @(negedge clk);
        ex_mem_kind = kind; ex_mem_width = w; ex_mem_addr = addr; ex_rd_data = data;
        ex_rd_addr = rd; ex_rd_enable = rden; rdy = 1'b1; mem_grant = 1'b0;
        #1;
        chk("c0_stall", 32'(stall_req), 1);
        chk("c0_req", 32'(mem_req), 0);
        chk("c0_wben", 32'(wb_rd_enable), 0);
        for (int c = 1; c < 64 && !done; c++) begin
            @(negedge clk);
            rdy = !(g < n && (rdylo_mask[c % 16] || (rnd && $urandom_range(0, 7) == 0)));
            mem_grant = !nogrant_mask[c % 16] && !(rnd && $urandom_range(0, 3) == 0);
            if (c == abort_cycle) begin
                rst = 1'b1;
                $display("ABORT kind=%0d w=%0d addr=%h at cycle %0d", kind, w, addr, c);
                return;
            end
            #1;
            if (g < n) begin
                if (!rdy) begin
                    chk("hold_req", 32'(mem_req), 0);
                    chk("hold_stall", 32'(stall_req), 1);
                    chk("hold_wben", 32'(wb_rd_enable), 0);
                end else begin
                    chk("xfer_req", 32'(mem_req), 1);
                    chk("xfer_addr", mem_a, addr + g);
                    chk("xfer_we", 32'(mem_we), 32'(is_store));
                    if (is_store) chk("xfer_dout", 32'(mem_dout), 32'(8'(data >> (8 * g))));
                    if (mem_grant) g++;
                    chk("xfer_wben", 32'(wb_rd_enable), 0);
                    if (is_store && g == n) begin
                        chk("st_done_stall", 32'(stall_req), 0);
                        done = 1;
                    end else begin
                        chk("xfer_stall", 32'(stall_req), 1);
                    end
                end
            end else begin
                chk("ld_stall", 32'(stall_req), 0);
                chk("ld_req", 32'(mem_req), 0);
                chk("ld_wben", 32'(wb_rd_enable), 32'(rden));
                chk("ld_rd", 32'(wb_rd_addr), 32'(rd));
                chk("ld_data", wb_rd_data, exp_load(w, addr));
                done = 1;
            end
            if (done && exp_latency >= 0) chk("latency", c, exp_latency);
            if (done) $display("%s w=%0d addr=%h data=%h rd=%0d done cycle %0d",
                               is_store ? "STORE" : "LOAD", w, addr,
                               is_store ? data : wb_rd_data, rd, c);
        end
        chk("timeout", 32'(done), 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wbdata"}, wb_rd_data, 0);
        chk({tag, "_wbrd"}, 32'(wb_rd_addr), 0);
        chk({tag, "_wben"}, 32'(wb_rd_enable), 0);
        chk({tag, "_stall"}, 32'(stall_req), 0);
        chk({tag, "_req"}, 32'(mem_req), 0);
        chk({tag, "_we"}, 32'(mem_we), 0);
        chk({tag, "_a"}, mem_a, 0);
        chk({tag, "_dout"}, 32'(mem_dout), 0);
    endtask

    initial begin
        logic [2:0] ld_codes [5];
        ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("rst");
        $display("RESET outputs checked");
        @(negedge clk);
        rst = 1'b0;

        alu_op(32'h1234, 5'd5, 1'b1);
        run_op(2'b01, 3'b010, 32'h100, 32'h0, 5'd7, 1'b1, 0, 16'h0, 16'h0, -1, 5);
        run_op(2'b01, 3'b000, 32'h200, 32'h0, 5'd3, 1'b1, 0, 16'h0, 16'h0, -1, 2);
        run_op(2'b01, 3'b100, 32'h200, 32'h0, 5'd4, 1'b1, 0, 16'h0, 16'h0, -1, 2);
        run_op(2'b01, 3'b001, 32'h201, 32'h0, 5'd6, 1'b1, 0, 16'h0, 16'h0, -1, 3);
        run_op(2'b01, 3'b101, 32'h201, 32'h0, 5'd6, 1'b1, 0, 16'h0, 16'h0, -1, 3);
        run_op(2'b10, 3'b001, 32'h300, 32'hAABBCCDD, 5'd9, 1'b1, 0, 16'h0002, 16'h0, -1, 3);
        run_op(2'b10, 3'b000, 32'h400, 32'h11223344, 5'd1, 1'b1, 0, 16'h0, 16'h0, -1, 1);
        run_op(2'b10, 3'b010, 32'h501, 32'hCAFEBABE, 5'd2, 1'b0, 0, 16'h0, 16'h0, -1, 4);
        run_op(2'b01, 3'b010, 32'hFFFFFFFE, 32'h0, 5'd8, 1'b1, 0, 16'h0, 16'h0, -1, 5);
        run_op(2'b01, 3'b010, 32'h100, 32'h0, 5'd10, 1'b1, 0, 16'h0, 16'h000C, -1, 7);
        run_op(2'b01, 3'b010, 32'h100, 32'h0, 5'd11, 1'b1, 0, 16'h0, 16'h0, 3, -1);

        @(negedge clk);
        rst = 1'b0;
        ex_mem_kind = 2'b00; ex_rd_data = '0; ex_rd_addr = '0; ex_rd_enable = 1'b0;
        ex_mem_width = '0; ex_mem_addr = '0; rdy = 1'b1; mem_grant = 1'b1;
        #1;
        chk_all_zero("abort");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_req", 32'(mem_req), 0);
            chk("post_rst_stall", 32'(stall_req), 0);
        end
        $display("RESET mid-access checked");

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = $urandom_range(0, 2);
            if (sel == 0)
                alu_op($urandom, 5'($urandom), 1'($urandom));
            else if (sel == 1)
                run_op(2'b01, ld_codes[$urandom_range(0, 4)], $urandom, $urandom,
                       5'($urandom), 1'($urandom), 1, 16'h0, 16'h0, -1, -1);
            else
                run_op(2'b10, 3'($urandom_range(0, 2)), $urandom, $urandom,
                       5'($urandom), 1'($urandom), 1, 16'h0, 16'h0, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
